alu_wb_stage: RTL

Writeback stage directly downstream of the 8-bit ALU. Captures each ALU result with its carry/zero outputs, operation code and destination register into a 2-entry in-order buffer, then drives the register-file write port under a ready handshake. Maintains the architectural carry and zero flag registers, updated in program order as entries retire.

---
 rtl/alu_wb_stage_if.sv | 38 +++
 rtl/alu_wb_stage.sv | 79 +++++++
 2 files changed

// File: rtl/alu_wb_stage_if.sv
// alu_wb_stage_if: ALU-result input, register-file write port, flags and optional bypass port (WB_BYPASS_EN).
interface alu_wb_stage_if #(parameter int DATA_W = 8, parameter int ADDR_W = 3);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_carry;
    logic              in_zero;
    logic [2:0]        in_op;
    logic [ADDR_W-1:0] in_rd;
    logic              in_wen;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_ready;
    logic              flag_c;
    logic              flag_z;
`ifdef WB_BYPASS_EN
    logic [ADDR_W-1:0] fwd_raddr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
`endif
    modport slave (
        input  in_valid, in_result, in_carry, in_zero, in_op, in_rd, in_wen, rf_ready,
`ifdef WB_BYPASS_EN
        input  fwd_raddr,
        output fwd_hit, fwd_data,
`endif
        output in_ready, rf_we, rf_waddr, rf_wdata, flag_c, flag_z
    );
    modport master (
        output in_valid, in_result, in_carry, in_zero, in_op, in_rd, in_wen, rf_ready,
`ifdef WB_BYPASS_EN
        output fwd_raddr,
        input  fwd_hit, fwd_data,
`endif
        input  in_ready, rf_we, rf_waddr, rf_wdata, flag_c, flag_z
    );
endinterface

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: 2-entry in-order writeback buffer driving the register-file write port and carry/zero flags.
// Optional WB_BYPASS_EN adds a combinational forwarding lookup over pending writes.
module alu_wb_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input logic            clk,
    input logic            rst_n,
    alu_wb_stage_if.slave  bus
);
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              carry;
        logic              zero;
        logic [2:0]        op;
        logic [ADDR_W-1:0] rd;
        logic              wen;
    } entry_t;

    entry_t     ent_q [2];
    entry_t     ent_d [2];
    logic [1:0] count_q, count_d;
    logic       head_q, head_d;
    logic       tail_q, tail_d;
    logic       flag_c_q, flag_c_d;
    logic       flag_z_q, flag_z_d;
    logic       push, retire;

    assign bus.in_ready = count_q != 2'd2;
    assign bus.rf_we    = (count_q != 2'd0) & ent_q[head_q].wen;
    assign bus.rf_waddr = ent_q[head_q].rd;
    assign bus.rf_wdata = ent_q[head_q].result;
    assign bus.flag_c   = flag_c_q;
    assign bus.flag_z   = flag_z_q;

    // Flags-only entries retire without waiting on the register file.
    always_comb begin
        push     = bus.in_valid & bus.in_ready;
        retire   = (count_q != 2'd0) & (~ent_q[head_q].wen | bus.rf_ready);
        ent_d    = ent_q;
        if (push) ent_d[tail_q] = '{bus.in_result, bus.in_carry, bus.in_zero, bus.in_op, bus.in_rd, bus.in_wen};
        head_d   = head_q ^ retire;
        tail_d   = tail_q ^ push;
        count_d  = count_q + 2'(push) - 2'(retire);
        flag_c_d = (retire && ent_q[head_q].op == 3'b000) ? ent_q[head_q].carry : flag_c_q;
        flag_z_d = retire ? ent_q[head_q].zero : flag_z_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

`ifdef WB_BYPASS_EN
    logic hit_y, hit_o;
    // With two entries the one behind the head is the youngest and takes priority.
    always_comb begin
        hit_y        = (count_q == 2'd2) & ent_q[~head_q].wen & (ent_q[~head_q].rd == bus.fwd_raddr);
        hit_o        = (count_q != 2'd0) & ent_q[head_q].wen & (ent_q[head_q].rd == bus.fwd_raddr);
        bus.fwd_hit  = hit_y | hit_o;
        bus.fwd_data = hit_y ? ent_q[~head_q].result : hit_o ? ent_q[head_q].result : '0;
    end
`endif
endmodule
